// File: rtl/riscv_definitions_pkg.sv
// Shared types for the instruction fetch queue: FIFO entry layout, NOP encoding, IF state.
package riscv_definitions;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

    typedef enum logic [1:0] {
        IF_RUN   = 2'd0,
        IF_FAULT = 2'd1,
        IF_HALT  = 2'd2
    } if_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Generic power-of-two circular FIFO with synchronous clear; a pop and a push
// in the same cycle are both accepted even when the FIFO is full.
module fetch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [31:0]
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           do_push, do_pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW+1)'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only observable through a valid count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/instruction_fetch_queue.sv
// Decoupled IF stage: req/gnt/rvalid memory port, credit-limited prefetch FIFO, flush redirect.
// Optional macro IF_MISALIGN_CHECK_EN adds misaligned-redirect fault reporting (o_if_fault).
module instruction_fetch_queue
    import riscv_definitions::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_jump_addr,
    output logic            o_inst_req,
    output logic [XLEN-1:0] o_inst_addr,
    input  logic            i_inst_gnt,
    input  logic            i_inst_rvalid,
    input  logic [XLEN-1:0] i_inst_rdata,
    output logic            o_if_valid,
    output logic [XLEN-1:0] o_if_inst,
    output logic [XLEN-1:0] o_if_pc,
    input  logic            i_id_ready
`ifdef IF_MISALIGN_CHECK_EN
    ,
    output logic            o_if_fault
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = CW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [DW-1:0]   discard_q, discard_d;
    logic            req_en_q;
    if_state_e       state_q;

    logic [XLEN-1:0] jump_addr;
    logic            run, fault_view, credit_ok, grant;
    logic            rsp_take, rsp_drop;
    logic [DW-1:0]   in_flight;

    entry_t          fifo_head, fifo_wdata;
    logic            fifo_full, fifo_empty, fifo_pop;
    logic [CW-1:0]   fifo_count;
    logic [XLEN-1:0] pcq_head;
    logic            pcq_full, pcq_empty;
    logic [CW-1:0]   pcq_count;

`ifdef IF_MISALIGN_CHECK_EN
    assign jump_addr  = i_jump_addr;
    assign fault_view = (state_q == IF_FAULT);
    assign o_if_fault = fault_view;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IF_RUN;
        end else if (i_flush) begin
            state_q <= (i_jump_addr[1:0] != 2'b00) ? IF_FAULT : IF_RUN;
        end else if (state_q == IF_FAULT && i_id_ready) begin
            state_q <= IF_HALT;
        end
    end
`else
    // Without the check, redirect targets are forced word-aligned.
    assign jump_addr  = i_jump_addr & ~XLEN'(3);
    assign fault_view = 1'b0;
    assign state_q    = IF_RUN;
`endif

    // The PC queue depth equals the number of live outstanding fetches, since it
    // is cleared on flush and only popped by responses that are kept.
    always_comb begin
        run        = (state_q == IF_RUN);
        credit_ok  = ({1'b0, fifo_count} + {1'b0, pcq_count}) < (CW+1)'(FIFO_DEPTH);
        o_inst_req = req_en_q && run && !i_flush && credit_ok && !fifo_full && !pcq_full;
        grant      = o_inst_req && i_inst_gnt;
        rsp_drop   = i_inst_rvalid && (discard_q != '0);
        rsp_take   = i_inst_rvalid && (discard_q == '0) && !pcq_empty && !i_flush;
        in_flight  = discard_q + DW'(pcq_count);
        fifo_pop   = i_id_ready && !fifo_empty;
        fifo_wdata = '{pc: pcq_head, inst: i_inst_rdata};

        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;
        if (i_flush) begin
            fetch_pc_d = jump_addr;
            discard_d  = in_flight - DW'(i_inst_rvalid && (in_flight != '0));
        end else begin
            if (grant)    fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (rsp_drop) discard_d  = discard_q - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            discard_q  <= '0;
            req_en_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            req_en_q   <= 1'b1;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [XLEN-1:0])) u_pc_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (i_flush),
        .push      (grant),
        .push_data (fetch_pc_q),
        .pop       (rsp_take),
        .head      (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .T(entry_t)) u_prefetch (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (i_flush),
        .push      (rsp_take),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Fault entry is synthesised from the held redirect PC; FIFO is empty then.
    always_comb begin
        o_inst_addr = fetch_pc_q;
        o_if_valid  = fault_view || !fifo_empty;
        o_if_pc     = '0;
        o_if_inst   = XLEN'(NOP_INST);
        if (fault_view) begin
            o_if_pc = fetch_pc_q;
        end else if (!fifo_empty) begin
            o_if_pc   = fifo_head.pc;
            o_if_inst = fifo_head.inst;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed scoreboard bench for instruction_fetch_queue with a 1-cycle-latency memory model.
module tb_instruction_fetch_queue;
    import riscv_definitions::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_flush;
    logic [31:0] i_jump_addr;
    logic        o_inst_req;
    logic [31:0] o_inst_addr;
    logic        i_inst_gnt;
    logic        i_inst_rvalid;
    logic [31:0] i_inst_rdata;
    logic        o_if_valid;
    logic [31:0] o_if_inst;
    logic [31:0] o_if_pc;
    logic        i_id_ready;
`ifdef IF_MISALIGN_CHECK_EN
    logic        o_if_fault;
`endif

    always #5 clk = ~clk;

    instruction_fetch_queue #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_flush       (i_flush),
        .i_jump_addr   (i_jump_addr),
        .o_inst_req    (o_inst_req),
        .o_inst_addr   (o_inst_addr),
        .i_inst_gnt    (i_inst_gnt),
        .i_inst_rvalid (i_inst_rvalid),
        .i_inst_rdata  (i_inst_rdata),
        .o_if_valid    (o_if_valid),
        .o_if_inst     (o_if_inst),
        .o_if_pc       (o_if_pc),
        .i_id_ready    (i_id_ready)
`ifdef IF_MISALIGN_CHECK_EN
        ,
        .o_if_fault    (o_if_fault)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] memq[$];
    int          errors = 0, checks = 0, cyc = 0, grants = 0;
    int          first_grant = -1, first_valid = -1;
    logic [31:0] exp_addr;
    bit          hold = 0, ready_en = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5A00_0003;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] p;
            p = pc + 32'(4 * i);
            sb.push_back('{pc: p, inst: inst_of(p), fault: 1'b0});
        end
    endtask

    // One clock cycle starting and ending at a falling edge.
    task automatic cycle();
        i_id_ready = ready_en && (sb.size() != 0);
        #1;
        if (o_if_valid && first_valid < 0) first_valid = cyc;
        if (o_if_valid && i_id_ready) begin
            exp_t e;
            e = sb.pop_front();
            check("pop_pc", o_if_pc, e.pc);
            check("pop_inst", o_if_inst, e.inst);
`ifdef IF_MISALIGN_CHECK_EN
            check("pop_fault", 32'(o_if_fault), 32'(e.fault));
`endif
        end
        if (o_inst_req && i_inst_gnt) begin
            if (first_grant < 0) first_grant = cyc;
            grants++;
            check("grant_addr", o_inst_addr, exp_addr);
            exp_addr = exp_addr + 32'd4;
            memq.push_back(o_inst_addr);
        end
        @(negedge clk);
        i_flush = 1'b0;
        if (!hold && memq.size() != 0) begin
            i_inst_rvalid = 1'b1;
            i_inst_rdata  = inst_of(memq.pop_front());
        end else begin
            i_inst_rvalid = 1'b0;
            i_inst_rdata  = 32'h0;
        end
        cyc++;
    endtask

    task automatic do_flush(input logic [31:0] addr);
        i_flush     = 1'b1;
        i_jump_addr = addr;
`ifdef IF_MISALIGN_CHECK_EN
        exp_addr = addr;
`else
        exp_addr = addr & ~32'h3;
`endif
        cycle();
    endtask

    task automatic drain(input string tag, input int max);
        for (int i = 0; i < max && sb.size() != 0; i++) cycle();
        check({"drain_", tag}, 32'(sb.size()), 32'd0);
    endtask

    task automatic settle();
        i_inst_gnt = 1'b0;
        hold       = 0;
        ready_en   = 0;
        repeat (6) cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; i_flush = 1'b0; i_jump_addr = '0; i_inst_gnt = 1'b0;
        i_inst_rvalid = 1'b0; i_inst_rdata = '0; i_id_ready = 1'b0; exp_addr = 32'h0;
        #2;
        check("rst_req", 32'(o_inst_req), 32'd0);
        check("rst_addr", o_inst_addr, 32'h0);
        check("rst_valid", 32'(o_if_valid), 32'd0);
        check("rst_inst", o_if_inst, NOP_INST);
        check("rst_pc", o_if_pc, 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Spurious response with nothing in flight is ignored.
        i_inst_rvalid = 1'b1; i_inst_rdata = 32'hBAD0_0000;
        cycle(); cycle();
        check("spurious_rvalid", 32'(o_if_valid), 32'd0);

        // Streaming: one instruction per cycle, gnt->valid latency of 2.
        i_inst_gnt = 1'b1; ready_en = 1;
        push_exp(32'h0, 8);
        drain("stream", 60);
        check("latency", 32'(first_valid - first_grant), 32'd2);

        // Back-pressure: credit limits grants to the FIFO depth.
        ready_en = 0;
        do_flush(32'h40);
        grants = 0;
        repeat (10) cycle();
        check("bp_grants", 32'(grants), 32'd4);
        check("bp_req_off", 32'(o_inst_req), 32'd0);
        push_exp(32'h40, 4); ready_en = 1;
        drain("bp", 30);

        // Flush with three fetches outstanding; their responses must be dropped.
        settle();
        hold = 1;
        do_flush(32'h80);
        grants = 0; i_inst_gnt = 1'b1;
        repeat (3) cycle();
        i_inst_gnt = 1'b0;
        check("out3_grants", 32'(grants), 32'd3);
        cycle();
        do_flush(32'h100);
        check("out3_empty", 32'(o_if_valid), 32'd0);
        i_inst_gnt = 1'b1; hold = 0;
        push_exp(32'h100, 4); ready_en = 1;
        drain("out3", 40);

        // Flush in the same cycle as a response, one more still in flight.
        settle();
        hold = 1; i_inst_gnt = 1'b1;
        do_flush(32'h200);
        cycle();
        hold = 0;
        cycle();
        do_flush(32'h300);
        check("rvflush_empty", 32'(o_if_valid), 32'd0);
        push_exp(32'h300, 4); ready_en = 1;
        drain("rvflush", 40);

        // PC wrap at the top of the address space.
        settle();
        i_inst_gnt = 1'b1;
        do_flush(32'hFFFF_FFF8);
        push_exp(32'hFFFF_FFF8, 4); ready_en = 1;
        drain("wrap", 40);

        // Misaligned redirect.
        settle();
        i_inst_gnt = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
        do_flush(32'h102);
        grants = 0;
        repeat (5) cycle();
        check("fault_grants", 32'(grants), 32'd0);
        check("fault_valid", 32'(o_if_valid), 32'd1);
        check("fault_flag", 32'(o_if_fault), 32'd1);
        check("fault_pc", o_if_pc, 32'h102);
        check("fault_inst", o_if_inst, NOP_INST);
        sb.push_back('{pc: 32'h102, inst: NOP_INST, fault: 1'b1});
        ready_en = 1;
        drain("fault", 10);
        repeat (5) cycle();
        check("halt_grants", 32'(grants), 32'd0);
        check("halt_valid", 32'(o_if_valid), 32'd0);
        do_flush(32'h200);
        push_exp(32'h200, 2);
        drain("resume", 30);
`else
        do_flush(32'h102);
        push_exp(32'h100, 2); ready_en = 1;
        drain("misalign", 30);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
